// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- instruction-fetch stage of the simple MIPS core.
//
// Holds the program counter, fetches from instruction memory over a
// single-cycle req/ready handshake and drives the IF/ID pipeline register.
// Taken branches and jumps from decode redirect the PC; a hazard stall from
// downstream freezes IF/ID and blocks redirects. An instruction that returns
// while stalled is parked in a one-entry skid buffer (HOLD state) so that
// nothing is lost or duplicated when the stall releases.
//
// Ports:
//   clk            in   1   rising-edge clock
//   rst            in   1   asynchronous active-high reset
//   imem_req       out  1   fetch request (high only in FETCH)
//   imem_addr      out  32  fetch byte address, always the current PC
//   imem_rdata     in   32  instruction word, valid when imem_req & imem_ready
//   imem_ready     in   1   memory accepts the request and returns data now
//   stall          in   1   hazard stall; holds IF/ID and blocks redirects
//   branch_taken   in   1   taken-branch redirect from decode
//   branch_target  in   32  branch target address
//   jump           in   1   jump redirect from decode (wins over branch)
//   jump_target    in   32  jump target address
//   id_instr       out  32  IF/ID instruction; [31:26] is the decoder opcode
//   id_pc_plus4    out  32  IF/ID PC+4 of id_instr
//   id_valid       out  1   IF/ID holds a real instruction (0 = bubble)
//   fetch_count    out  32  instructions delivered into IF/ID, wraps mod 2^32
// -----------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4,
    output logic        id_valid,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Word alignment mask applied to every redirect target.
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    state_t      state_q,       state_d;
    logic [31:0] pc_q,          pc_d;
    logic [31:0] buf_instr_q,   buf_instr_d;
    logic [31:0] buf_pc4_q,     buf_pc4_d;
    logic [31:0] id_instr_q,    id_instr_d;
    logic [31:0] id_pc4_q,      id_pc4_d;
    logic        id_valid_q,    id_valid_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic        redirect_s;
    logic [31:0] target_s;
    logic [31:0] pc_plus4_s;

    // Redirect qualification, target selection and sequential PC increment.
    always_comb begin
        redirect_s = (branch_taken | jump) & ~stall;
        if (jump) begin
            target_s = jump_target & ALIGN_MASK;
        end else begin
            target_s = branch_target & ALIGN_MASK;
        end
        // Plain 32-bit add: 0xFFFF_FFFC + 4 wraps to 0.
        pc_plus4_s = pc_q + 32'd4;
    end

    // Next-state logic for the fetch FSM, PC, skid buffer and IF/ID register.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        buf_instr_d   = buf_instr_q;
        buf_pc4_d     = buf_pc4_q;
        id_instr_d    = id_instr_q;
        id_pc4_d      = id_pc4_q;
        id_valid_d    = id_valid_q;
        fetch_count_d = fetch_count_q;

        case (state_q)
            ST_BOOT: begin
                // One idle cycle after reset before the first request.
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                if (stall && imem_ready) begin
                    // Data arrived but IF/ID is frozen: park it and advance.
                    buf_instr_d = imem_rdata;
                    buf_pc4_d   = pc_plus4_s;
                    pc_d        = pc_plus4_s;
                    state_d     = ST_HOLD;
                end else if (stall) begin
                    state_d = ST_FETCH;
                end else if (redirect_s) begin
                    // No delay slot: the word returned this cycle is dropped.
                    pc_d       = target_s;
                    id_valid_d = 1'b0;
                end else if (imem_ready) begin
                    id_instr_d    = imem_rdata;
                    id_pc4_d      = pc_plus4_s;
                    id_valid_d    = 1'b1;
                    pc_d          = pc_plus4_s;
                    fetch_count_d = fetch_count_q + 32'd1;
                end else begin
                    // Wait state: emit a bubble, keep IF/ID payload as is.
                    id_valid_d = 1'b0;
                end
            end

            ST_HOLD: begin
                if (stall) begin
                    state_d = ST_HOLD;
                end else if (redirect_s) begin
                    // Buffered instruction is on the wrong path.
                    pc_d       = target_s;
                    id_valid_d = 1'b0;
                    state_d    = ST_FETCH;
                end else begin
                    id_instr_d    = buf_instr_q;
                    id_pc4_d      = buf_pc4_q;
                    id_valid_d    = 1'b1;
                    fetch_count_d = fetch_count_q + 32'd1;
                    state_d       = ST_FETCH;
                end
            end

            default: begin
                state_d    = ST_BOOT;
                pc_d       = RESET_PC;
                id_valid_d = 1'b0;
            end
        endcase
    end

    // State, PC, skid buffer and IF/ID registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            buf_instr_q   <= 32'd0;
            buf_pc4_q     <= 32'd0;
            id_instr_q    <= 32'd0;
            id_pc4_q      <= 32'd0;
            id_valid_q    <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            buf_instr_q   <= buf_instr_d;
            buf_pc4_q     <= buf_pc4_d;
            id_instr_q    <= id_instr_d;
            id_pc4_q      <= id_pc4_d;
            id_valid_q    <= id_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Memory-side outputs depend only on state and PC (no input paths).
    always_comb begin
        imem_req  = (state_q == ST_FETCH);
        imem_addr = pc_q;
    end

    assign id_instr    = id_instr_q;
    assign id_pc_plus4 = id_pc4_q;
    assign id_valid    = id_valid_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage -- directed self-checking bench for if_stage.
// Memory model: the word at byte address A is A+1, ready is driven directly.
// -----------------------------------------------------------------------------
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;
    logic        id_valid;
    logic [31:0] fetch_count;

    int cmp_cnt;
    int err_cnt;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_ready   (imem_ready),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .id_instr     (id_instr),
        .id_pc_plus4  (id_pc_plus4),
        .id_valid     (id_valid),
        .fetch_count  (fetch_count)
    );

    assign imem_rdata = imem_addr + 32'd1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp)
        else begin
            err_cnt++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the full IF/ID register contents.
    task automatic chk_id(input string tag, input logic [31:0] ins, input logic [31:0] pc4,
                          input logic vld, input logic [31:0] cnt);
        chk({tag, ".instr"}, id_instr, ins);
        chk({tag, ".pc4"},   id_pc_plus4, pc4);
        chk({tag, ".valid"}, {31'd0, id_valid}, {31'd0, vld});
        chk({tag, ".count"}, fetch_count, cnt);
    endtask

    task automatic chk_mem(input string tag, input logic req, input logic [31:0] addr);
        chk({tag, ".req"},  {31'd0, imem_req}, {31'd0, req});
        chk({tag, ".addr"}, imem_addr, addr);
    endtask

    initial begin
        cmp_cnt       = 0;
        err_cnt       = 0;
        rst           = 1'b1;
        imem_ready    = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'd0;
        jump          = 1'b0;
        jump_target   = 32'd0;

        // Reset values.
        #2;
        chk_id("rst", 32'd0, 32'd0, 1'b0, 32'd0);
        chk_mem("rst", 1'b0, 32'd0);
        step();
        step();
        rst = 1'b0;

        // BOOT cycle: no request yet.
        chk_mem("boot", 1'b0, 32'd0);
        step();
        chk_mem("first_req", 1'b1, 32'd0);

        // Zero-wait streaming.
        step();
        chk_id("s0", 32'd1, 32'd4, 1'b1, 32'd1);
        step();
        chk_id("s1", 32'd5, 32'd8, 1'b1, 32'd2);
        step();
        chk_id("s2", 32'd9, 32'd12, 1'b1, 32'd3);
        step();
        chk_id("s3", 32'd13, 32'h10, 1'b1, 32'd4);
        chk_mem("s3", 1'b1, 32'h10);

        // Two wait states at pc=0x10.
        imem_ready = 1'b0;
        step();
        chk("ws0.valid", {31'd0, id_valid}, 32'd0);
        chk_mem("ws0", 1'b1, 32'h10);
        step();
        chk("ws1.valid", {31'd0, id_valid}, 32'd0);
        chk_mem("ws1", 1'b1, 32'h10);
        chk("ws1.instr", id_instr, 32'd13);
        imem_ready = 1'b1;
        step();
        chk_id("ws_done", 32'h11, 32'h14, 1'b1, 32'd5);

        // Run to pc=0x20.
        step();
        step();
        step();
        chk_id("pre_stall", 32'h1D, 32'h20, 1'b1, 32'd8);
        chk_mem("pre_stall", 1'b1, 32'h20);

        // Stall three cycles while 0x20 returns.
        stall = 1'b1;
        step();
        chk_mem("hold0", 1'b0, 32'h24);
        chk_id("hold0", 32'h1D, 32'h20, 1'b1, 32'd8);
        step();
        step();
        chk_mem("hold2", 1'b0, 32'h24);
        chk_id("hold2", 32'h1D, 32'h20, 1'b1, 32'd8);
        stall = 1'b0;
        step();
        chk_id("drain", 32'h21, 32'h24, 1'b1, 32'd9);
        chk_mem("drain", 1'b1, 32'h24);
        step();
        chk_id("after_drain", 32'h25, 32'h28, 1'b1, 32'd10);

        // Run to pc=0x40.
        for (int i = 0; i < 6; i++) step();
        chk_id("pre_br", 32'h3D, 32'h40, 1'b1, 32'd16);
        chk_mem("pre_br", 1'b1, 32'h40);

        // Taken branch from FETCH with ready=1.
        branch_taken  = 1'b1;
        branch_target = 32'h100;
        step();
        branch_taken = 1'b0;
        chk_id("br_bubble", 32'h3D, 32'h40, 1'b0, 32'd16);
        chk_mem("br_bubble", 1'b1, 32'h100);
        step();
        chk_id("br_tgt", 32'h101, 32'h104, 1'b1, 32'd17);

        // Jump and branch together: jump wins, target realigned.
        jump          = 1'b1;
        jump_target   = 32'h203;
        branch_taken  = 1'b1;
        branch_target = 32'h300;
        step();
        jump         = 1'b0;
        branch_taken = 1'b0;
        chk("jmp.valid", {31'd0, id_valid}, 32'd0);
        chk_mem("jmp", 1'b1, 32'h200);
        step();
        chk_id("jmp_tgt", 32'h201, 32'h204, 1'b1, 32'd18);

        // Redirect out of HOLD drops the buffer.
        stall = 1'b1;
        step();
        chk_mem("hold_br0", 1'b0, 32'h208);
        stall         = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h80;
        step();
        branch_taken = 1'b0;
        chk_id("hold_br", 32'h201, 32'h204, 1'b0, 32'd18);
        chk_mem("hold_br", 1'b1, 32'h80);
        step();
        chk_id("hold_br_tgt", 32'h81, 32'h84, 1'b1, 32'd19);

        // PC wrap at the top of the address space.
        jump        = 1'b1;
        jump_target = 32'hFFFF_FFFC;
        step();
        jump = 1'b0;
        chk_mem("wrap_req", 1'b1, 32'hFFFF_FFFC);
        step();
        chk_id("wrap", 32'hFFFF_FFFD, 32'h0, 1'b1, 32'd20);
        chk_mem("wrap", 1'b1, 32'h0);

        // Asynchronous reset in the middle of HOLD.
        stall = 1'b1;
        step();
        chk_mem("pre_rst_hold", 1'b0, 32'h4);
        #2;
        rst = 1'b1;
        #1;
        chk_id("async_rst", 32'd0, 32'd0, 1'b0, 32'd0);
        chk_mem("async_rst", 1'b0, 32'd0);
        stall = 1'b0;
        step();
        rst = 1'b0;
        chk_mem("reboot", 1'b0, 32'd0);
        step();
        chk_mem("reboot_req", 1'b1, 32'd0);
        step();
        chk_id("reboot_fetch", 32'd1, 32'd4, 1'b1, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
